// File: rtl/parallel_to_serial_pkg.sv
// Shared definitions for the parallel-to-serial transmit path.
package parallel_to_serial_pkg;

    // Default chunk and word widths (byte chunks of a 64-bit payload word).
    localparam int unsigned S_WIDTH_DEF = 8;
    localparam int unsigned P_WIDTH_DEF = 64;

    // Encodings are shared with the receive side, so they are pinned explicitly.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } p2s_state_e;

    // Number of serial chunks per parallel word.
    function automatic int unsigned count_max(input int unsigned p_width,
                                              input int unsigned s_width);
        return p_width / s_width;
    endfunction

endpackage

// File: rtl/parallel_to_serial.sv
// Splits a parallel word into serial chunks, MSB chunk first, with a one-word
// holding register so back-to-back words stream without a bubble.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int unsigned S_WIDTH = S_WIDTH_DEF,
    parameter int unsigned P_WIDTH = P_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [P_WIDTH-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [S_WIDTH-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy
);

    localparam int unsigned     COUNT_MAX = count_max(P_WIDTH, S_WIDTH);
    localparam int unsigned     CNT_W     = $clog2(COUNT_MAX);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT_MAX - 1);

    if ((P_WIDTH % S_WIDTH) != 0 || COUNT_MAX < 2) begin : g_param_check
        $error("P_WIDTH must be a multiple of S_WIDTH with at least two chunks");
    end

    p2s_state_e         r_state, w_state_d;
    logic [P_WIDTH-1:0] r_shift, w_shift_d;
    logic [P_WIDTH-1:0] r_hold,  w_hold_d;
    logic               r_hold_full, w_hold_full_d;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_d;

    logic w_in_fire;
    logic w_out_fire;
    logic w_last;
    logic w_bypass;

    assign in_ready   = ~r_hold_full;
    assign out_valid  = (r_state == SEND);
    assign w_last     = (r_state == SEND) && (r_cnt == LAST_CNT);
    assign out_last   = w_last;
    // Shift register is cleared on reset and in IDLE its contents are don't-care.
    assign out_data   = r_shift[P_WIDTH-1 -: S_WIDTH];
    assign busy       = (r_state == SEND) | r_hold_full;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    // Holding empty at the last chunk: the new word goes straight into the shifter.
    assign w_bypass   = w_out_fire & w_last & ~r_hold_full & w_in_fire;

    // State, shifter, holding register and chunk counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_d;
            r_shift     <= w_shift_d;
            r_hold      <= w_hold_d;
            r_hold_full <= w_hold_full_d;
            r_cnt       <= w_cnt_d;
        end
    end

    // Next-state logic; the shifter only moves on out_fire so a stalled chunk is stable.
    always_comb begin
        w_state_d     = r_state;
        w_shift_d     = r_shift;
        w_hold_d      = r_hold;
        w_hold_full_d = r_hold_full;
        w_cnt_d       = r_cnt;

        unique case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_shift_d = in_data;
                    w_cnt_d   = '0;
                    w_state_d = SEND;
                end
            end
            SEND: begin
                if (w_out_fire) begin
                    if (!w_last) begin
                        w_shift_d = r_shift << S_WIDTH;
                        w_cnt_d   = r_cnt + CNT_W'(1);
                    end else if (r_hold_full) begin
                        w_shift_d     = r_hold;
                        w_cnt_d       = '0;
                        w_hold_full_d = 1'b0;
                    end else if (w_in_fire) begin
                        w_shift_d = in_data;
                        w_cnt_d   = '0;
                    end else begin
                        w_state_d = IDLE;
                    end
                end
                if (w_in_fire && !w_bypass) begin
                    w_hold_d      = in_data;
                    w_hold_full_d = 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Scoreboard bench for parallel_to_serial: accepted words are expanded into
// expected chunks; a monitor checks every out_fire and reassembles whole words.
module tb_parallel_to_serial;

    localparam int unsigned S_W = 8;
    localparam int unsigned P_W = 64;
    localparam int unsigned N_CHUNK = P_W / S_W;

    logic           clk;
    logic           rst_n;
    logic [P_W-1:0] in_data;
    logic           in_valid;
    logic           in_ready;
    logic [S_W-1:0] out_data;
    logic           out_valid;
    logic           out_ready;
    logic           out_last;
    logic           busy;

    parallel_to_serial #(
        .S_WIDTH (S_W),
        .P_WIDTH (P_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fires  = 0;

    // Expected chunk stream ({last, data}) and expected reassembled words.
    logic [S_W:0]   exp_chunk_q[$];
    logic [P_W-1:0] exp_word_q[$];
    logic [P_W-1:0] rx_acc;

    // 0: always ready, 1: pattern 1,0,0, 2: random.
    int ready_mode = 0;
    int ready_ctr  = 0;

    task automatic check(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream ready generator, driven just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (ready_ctr % 3 == 0);
            default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
        ready_ctr++;
    end

    // Input observer: each accepted word becomes N_CHUNK expected chunks.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            for (int k = 0; k < N_CHUNK; k++) begin
                logic [S_W-1:0] c;
                c = in_data[P_W-1-k*S_W -: S_W];
                exp_chunk_q.push_back({(k == N_CHUNK - 1), c});
            end
            exp_word_q.push_back(in_data);
        end
    end

    // Output monitor: stall stability, chunk comparison and word reassembly.
    logic           prev_stall = 1'b0;
    logic [S_W-1:0] prev_data;
    logic           prev_last;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_data", P_W'(out_data), P_W'(prev_data));
                check("stall_last", P_W'(out_last), P_W'(prev_last));
            end
            if (out_valid && out_ready) begin
                n_fires++;
                if (exp_chunk_q.size() == 0) begin
                    check("unexpected_chunk", P_W'(out_data), '1);
                end else begin
                    logic [S_W:0] e;
                    e = exp_chunk_q.pop_front();
                    check("chunk_data", P_W'(out_data), P_W'(e[S_W-1:0]));
                    check("chunk_last", P_W'(out_last), P_W'(e[S_W]));
                end
                rx_acc = {rx_acc[P_W-S_W-1:0], out_data};
                if (out_last) begin
                    if (exp_word_q.size() == 0) check("unexpected_word", rx_acc, '1);
                    else check("loopback_word", rx_acc, exp_word_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Offer one word and return just after the rising edge that accepts it.
    task automatic send_word(input logic [P_W-1:0] w);
        bit ok = 0;
        @(posedge clk);
        #1;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        check("send_accept", P_W'(ok), P_W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_timeout", P_W'(busy), '0);
    endtask

    int n_before;
    int run_len;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        rx_acc    = '0;
        #23;
        check("rst_out_valid", P_W'(out_valid), '0);
        check("rst_in_ready",  P_W'(in_ready),  P_W'(1));
        check("rst_busy",      P_W'(busy),      '0);
        check("rst_out_data",  P_W'(out_data),  '0);
        check("rst_out_last",  P_W'(out_last),  '0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Single word, always ready: 8 consecutive valid cycles, then idle.
        ready_mode = 0;
        n_before = n_fires;
        send_word(64'h0123_4567_89AB_CDEF);
        for (int k = 0; k < N_CHUNK; k++) begin
            @(negedge clk);
            check("single_valid", P_W'(out_valid), P_W'(1));
            check("single_last", P_W'(out_last), P_W'(k == N_CHUNK - 1));
        end
        @(negedge clk);
        check("single_idle", P_W'(out_valid), '0);
        check("single_fires", P_W'(n_fires - n_before), P_W'(N_CHUNK));

        // Backpressure with ready pattern 1,0,0.
        ready_mode = 1;
        n_before = n_fires;
        send_word(64'h0123_4567_89AB_CDEF);
        wait_idle(200);
        check("bp_fires", P_W'(n_fires - n_before), P_W'(N_CHUNK));

        // Back-to-back: the second word is held and streams with no gap.
        ready_mode = 0;
        repeat (2) @(posedge clk);
        send_word(64'h1111_1111_1111_1111);
        run_len = 0;
        fork
            begin
                send_word(64'h2222_2222_2222_2222);
                @(negedge clk);
                check("b2b_in_ready_low", P_W'(in_ready), '0);
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (!out_valid) break;
                    run_len++;
                end
            end
        join
        check("b2b_run_len", P_W'(run_len), P_W'(2 * N_CHUNK));
        wait_idle(50);

        // Bypass: second word offered exactly on the last-chunk out_fire.
        send_word(64'hA1B2_C3D4_E5F6_0718);
        repeat (N_CHUNK - 1) @(posedge clk);
        #1;
        in_data  = 64'h5A69_7887_96A5_B4C3;
        in_valid = 1'b1;
        @(negedge clk);
        check("bypass_on_last", P_W'(out_last), P_W'(1));
        check("bypass_hold_empty", P_W'(in_ready), P_W'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bypass_valid", P_W'(out_valid), P_W'(1));
        check("bypass_msb", P_W'(out_data), P_W'(8'h5A));
        check("bypass_not_held", P_W'(in_ready), P_W'(1));
        wait_idle(50);

        // Asynchronous reset mid-word with a word also held pending.
        ready_mode = 1;
        send_word(64'hDEAD_BEEF_CAFE_F00D);
        send_word(64'h0BAD_F00D_1234_5678);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", P_W'(out_valid), '0);
        check("midrst_in_ready",  P_W'(in_ready),  P_W'(1));
        check("midrst_busy",      P_W'(busy),      '0);
        check("midrst_out_last",  P_W'(out_last),  '0);
        exp_chunk_q.delete();
        exp_word_q.delete();
        rx_acc = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", P_W'(out_valid), '0);
        check("post_rst_ready", P_W'(in_ready), P_W'(1));

        // Randomised loopback: 100 words, random gaps and random downstream ready.
        ready_mode = 2;
        for (int w = 0; w < 100; w++) begin
            send_word({$urandom, $urandom});
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle(2000);
        check("chunks_drained", P_W'(exp_chunk_q.size()), '0);
        check("words_drained",  P_W'(exp_word_q.size()),  '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
